// File: rtl/background_pkg.sv
// rtl/background_pkg.sv - shared types and constants for the background controller and drawer
//
// Holds the controller state enum, the default zone-line colors that the
// background drawer also uses, and the initial player-zone line position so
// both blocks agree on where the line sits after reset or restart.
package background_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FLASH  = 2'd2,
        ST_FROZEN = 2'd3
    } bg_state_t;

    localparam int PLAYER_ZONE_INIT_Y = 310;

    localparam logic [7:0] DEFAULT_PLAYER_ZONE_COLOR     = 8'b00010000;
    localparam logic [7:0] DEFAULT_MOVEMENT_ZONE_COLOR   = 8'b10000000;
    localparam logic [7:0] DEFAULT_STATISTICS_ZONE_COLOR = 8'b00000010;
    localparam logic [7:0] DEFAULT_FLASH_COLOR           = 8'b11111111;
    localparam logic [7:0] DEFAULT_GAME_OVER_COLOR       = 8'b11100000;

endpackage

// File: rtl/background_controller_if.sv
// rtl/background_controller_if.sv - event and line-configuration bundle between game logic and background controller
//
// master: game-logic side, drives the one-cycle event pulses and receives
//         the line configuration.
// slave : the controller, receives the events and drives the configuration.
//   startOfFrame, levelUp, playerHit, gameOver, restart : one-cycle pulses
//   player_zone_y                                       : player-zone line Y
//   player_zone_color, movement_zone_color,
//   statistics_zone_color                               : current line colors
//   busy                                                : high while shifting or flashing
interface background_controller_if #(
    parameter int PIXEL_WIDTH = 11,
    parameter int RGB_WIDTH   = 8
);
    logic                   startOfFrame;
    logic                   levelUp;
    logic                   playerHit;
    logic                   gameOver;
    logic                   restart;
    logic [PIXEL_WIDTH-1:0] player_zone_y;
    logic [RGB_WIDTH-1:0]   player_zone_color;
    logic [RGB_WIDTH-1:0]   movement_zone_color;
    logic [RGB_WIDTH-1:0]   statistics_zone_color;
    logic                   busy;

    modport master (
        output startOfFrame, levelUp, playerHit, gameOver, restart,
        input  player_zone_y, player_zone_color, movement_zone_color,
               statistics_zone_color, busy
    );

    modport slave (
        input  startOfFrame, levelUp, playerHit, gameOver, restart,
        output player_zone_y, player_zone_color, movement_zone_color,
               statistics_zone_color, busy
    );
endinterface

// File: rtl/flash_timer.sv
// rtl/flash_timer.sv - frame-based border flash sequencer
//
// Ports:
//   clk, resetN : pixel clock, asynchronous active-low reset
//   clear       : restart the sequence (counters and flash bit to zero)
//   tick        : one frame elapsed while flashing
//   done        : this tick completes the last toggle of the sequence
//   flash_bit   : current flash phase (1 = border shows the flash color)
module flash_timer #(
    parameter int FLASH_PERIOD  = 8,
    parameter int FLASH_TOGGLES = 6
) (
    input  logic clk,
    input  logic resetN,
    input  logic clear,
    input  logic tick,
    output logic done,
    output logic flash_bit
);
    localparam int FW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
    localparam int TW = $clog2(FLASH_TOGGLES + 1);

    localparam logic [FW-1:0] FRAME_LAST  = FW'(FLASH_PERIOD - 1);
    localparam logic [TW-1:0] TOGGLE_LAST = TW'(FLASH_TOGGLES - 1);

    logic [FW-1:0] frame_cnt;
    logic [TW-1:0] toggle_cnt;
    logic          period_end;

    assign period_end = (frame_cnt == FRAME_LAST);

    // Reported on the tick that performs the final toggle, so the controller
    // leaves FLASH on exactly the FLASH_PERIOD*FLASH_TOGGLES-th frame.
    assign done = tick && !clear && period_end && (toggle_cnt == TOGGLE_LAST);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt  <= '0;
            toggle_cnt <= '0;
            flash_bit  <= 1'b0;
        end else if (clear) begin
            frame_cnt  <= '0;
            toggle_cnt <= '0;
            flash_bit  <= 1'b0;
        end else if (tick) begin
            if (period_end) begin
                frame_cnt  <= '0;
                flash_bit  <= ~flash_bit;
                toggle_cnt <= toggle_cnt + TW'(1);
            end else begin
                frame_cnt  <= frame_cnt + FW'(1);
            end
        end
    end
endmodule

// File: rtl/background_controller.sv
// rtl/background_controller.sv - run-time sequencer for the background renderer's zone lines
//
// Ports:
//   clk    : VGA pixel clock
//   resetN : asynchronous active-low reset
//   bus    : slave side of background_controller_if (event pulses in,
//            player-zone Y, three line colors and busy out)
//
// Advances the player-zone line one pixel per frame toward a target raised by
// levelUp, flashes the movement-zone border after a hit, and freezes all lines
// in the game-over color until restart.
module background_controller #(
    parameter int PIXEL_WIDTH        = 11,
    parameter int RGB_WIDTH          = 8,
    parameter int PLAYER_ZONE_INIT_Y = background_pkg::PLAYER_ZONE_INIT_Y,
    parameter int PLAYER_ZONE_MAX_Y  = 400,
    parameter int LEVEL_DELTA        = 16,
    parameter int FLASH_PERIOD       = 8,
    parameter int FLASH_TOGGLES      = 6,
    parameter logic [RGB_WIDTH-1:0] PLAYER_ZONE_COLOR     = background_pkg::DEFAULT_PLAYER_ZONE_COLOR,
    parameter logic [RGB_WIDTH-1:0] MOVEMENT_ZONE_COLOR   = background_pkg::DEFAULT_MOVEMENT_ZONE_COLOR,
    parameter logic [RGB_WIDTH-1:0] STATISTICS_ZONE_COLOR = background_pkg::DEFAULT_STATISTICS_ZONE_COLOR,
    parameter logic [RGB_WIDTH-1:0] FLASH_COLOR           = background_pkg::DEFAULT_FLASH_COLOR,
    parameter logic [RGB_WIDTH-1:0] GAME_OVER_COLOR       = background_pkg::DEFAULT_GAME_OVER_COLOR
) (
    input  logic                    clk,
    input  logic                    resetN,
    background_controller_if.slave  bus
);
    import background_pkg::*;

    localparam logic [PIXEL_WIDTH-1:0] INIT_Y    = PIXEL_WIDTH'(PLAYER_ZONE_INIT_Y);
    localparam logic [PIXEL_WIDTH:0]   MAX_Y_EXT = (PIXEL_WIDTH + 1)'(PLAYER_ZONE_MAX_Y);
    localparam logic [PIXEL_WIDTH:0]   DELTA_EXT = (PIXEL_WIDTH + 1)'(LEVEL_DELTA);

    bg_state_t              state;
    logic [PIXEL_WIDTH-1:0] y;
    logic [PIXEL_WIDTH-1:0] target;
    logic [PIXEL_WIDTH-1:0] target_next;
    logic [PIXEL_WIDTH-1:0] y_inc;
    logic [PIXEL_WIDTH:0]   target_sum;
    logic                   busy_q;
    logic [RGB_WIDTH-1:0]   pz_color_q;
    logic [RGB_WIDTH-1:0]   mz_base_q;
    logic [RGB_WIDTH-1:0]   sz_color_q;
    logic                   timer_clear;
    logic                   timer_tick;
    logic                   timer_done;
    logic                   flash_bit;

    // One extra bit on the sum so a target near the top of the coordinate
    // range cannot wrap before it is compared with the saturation limit.
    always_comb begin
        target_sum  = {1'b0, target} + DELTA_EXT;
        target_next = target;
        if (bus.levelUp) begin
            target_next = (target_sum > MAX_Y_EXT) ? MAX_Y_EXT[PIXEL_WIDTH-1:0]
                                                   : target_sum[PIXEL_WIDTH-1:0];
        end
    end

    assign y_inc = y + PIXEL_WIDTH'(1);

    // gameOver clears the flash so FROZEN never shows a stale flash phase.
    // A hit restarts the sequence; clear outranks tick inside the timer, so a
    // frame pulse coincident with the hit is not counted.
    assign timer_clear = bus.gameOver | (bus.playerHit & (state != ST_FROZEN));
    assign timer_tick  = bus.startOfFrame & (state == ST_FLASH);

    flash_timer #(
        .FLASH_PERIOD  (FLASH_PERIOD),
        .FLASH_TOGGLES (FLASH_TOGGLES)
    ) u_flash_timer (
        .clk       (clk),
        .resetN    (resetN),
        .clear     (timer_clear),
        .tick      (timer_tick),
        .done      (timer_done),
        .flash_bit (flash_bit)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= ST_IDLE;
            y          <= INIT_Y;
            target     <= INIT_Y;
            busy_q     <= 1'b0;
            pz_color_q <= PLAYER_ZONE_COLOR;
            mz_base_q  <= MOVEMENT_ZONE_COLOR;
            sz_color_q <= STATISTICS_ZONE_COLOR;
        end else if (bus.gameOver) begin
            state      <= ST_FROZEN;
            busy_q     <= 1'b0;
            pz_color_q <= GAME_OVER_COLOR;
            mz_base_q  <= GAME_OVER_COLOR;
            sz_color_q <= GAME_OVER_COLOR;
        end else if (state == ST_FROZEN) begin
            if (bus.restart) begin
                state      <= ST_IDLE;
                y          <= INIT_Y;
                target     <= INIT_Y;
                pz_color_q <= PLAYER_ZONE_COLOR;
                mz_base_q  <= MOVEMENT_ZONE_COLOR;
                sz_color_q <= STATISTICS_ZONE_COLOR;
            end
        end else begin
            // levelUp applies even when a same-cycle hit wins the state change.
            target <= target_next;
            if (bus.playerHit) begin
                state  <= ST_FLASH;
                busy_q <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.levelUp && (target_next != y)) begin
                            state  <= ST_SHIFT;
                            busy_q <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (bus.startOfFrame) begin
                            y <= y_inc;
                            if (y_inc >= target_next) begin
                                state  <= ST_IDLE;
                                busy_q <= 1'b0;
                            end
                        end
                    end
                    ST_FLASH: begin
                        if (timer_done) begin
                            if (y != target_next) begin
                                state <= ST_SHIFT;
                            end else begin
                                state  <= ST_IDLE;
                                busy_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.player_zone_y         = y;
    assign bus.player_zone_color     = pz_color_q;
    assign bus.statistics_zone_color = sz_color_q;
    // Both mux inputs are flops; flash_bit is held at 0 while FROZEN.
    assign bus.movement_zone_color   = flash_bit ? FLASH_COLOR : mz_base_q;
    assign bus.busy                  = busy_q;
endmodule

// File: tb/tb_background_controller.sv
// tb/tb_background_controller.sv - self-checking bench for background_controller
module tb_background_controller;
    localparam int INIT_Y = 310;
    localparam int MAX_Y  = 400;
    localparam int DELTA  = 16;
    localparam int FLASH_FRAMES = 48;
    localparam logic [35:0] RST_VEC = {11'd310, 8'h10, 8'h80, 8'h02, 1'b0};

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    background_controller_if #(.PIXEL_WIDTH(11), .RGB_WIDTH(8)) bus();

    background_controller dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0 idle, 1 shifting, 2 flashing, 3 frozen;
    // m_ff counts frames elapsed since the flash started.
    int m_y, m_target, m_mode, m_ff;

    function automatic void model_reset();
        m_y = INIT_Y; m_target = INIT_Y; m_mode = 0; m_ff = 0;
    endfunction

    function automatic void model_step(input bit sof, lu, ph, go, rs);
        if (go) begin
            m_mode = 3; m_ff = 0;
            return;
        end
        if (m_mode == 3) begin
            if (rs) begin m_y = INIT_Y; m_target = INIT_Y; m_mode = 0; end
            return;
        end
        if (lu) m_target = (m_target + DELTA > MAX_Y) ? MAX_Y : m_target + DELTA;
        if (ph) begin
            m_mode = 2; m_ff = 0;
            return;
        end
        if (m_mode == 0) begin
            if (lu && m_target != m_y) m_mode = 1;
        end else if (m_mode == 1) begin
            if (sof) begin
                m_y++;
                if (m_y == m_target) m_mode = 0;
            end
        end else if (m_mode == 2) begin
            if (sof) begin
                m_ff++;
                if (m_ff == FLASH_FRAMES) m_mode = (m_y != m_target) ? 1 : 0;
            end
        end
    endfunction

    function automatic logic [35:0] exp_vec();
        logic [7:0] pc, mc, sc;
        logic b;
        if (m_mode == 3) begin
            pc = 8'hE0; mc = 8'hE0; sc = 8'hE0;
        end else begin
            pc = 8'h10; sc = 8'h02;
            mc = (m_mode == 2 && ((m_ff / 8) % 2) == 1) ? 8'hFF : 8'h80;
        end
        b = (m_mode == 1 || m_mode == 2);
        return {11'(m_y), pc, mc, sc, b};
    endfunction

    function automatic logic [35:0] act_vec();
        return {bus.player_zone_y, bus.player_zone_color, bus.movement_zone_color,
                bus.statistics_zone_color, bus.busy};
    endfunction

    task automatic step(input bit sof, lu, ph, go, rs);
        bus.startOfFrame = sof; bus.levelUp = lu; bus.playerHit = ph;
        bus.gameOver = go; bus.restart = rs;
        model_step(sof, lu, ph, go, rs);
        @(posedge clk); #1;
        bus.startOfFrame = 0; bus.levelUp = 0; bus.playerHit = 0;
        bus.gameOver = 0; bus.restart = 0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        bus.startOfFrame = 0; bus.levelUp = 0; bus.playerHit = 0;
        bus.gameOver = 0; bus.restart = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 resetN = 1'b1;
        n_checks++;
        if (act_vec() !== RST_VEC) begin
            n_fail++; $display("FAIL reset_values act=%h exp=%h", act_vec(), RST_VEC);
        end
        step(1, 0, 0, 0, 0);
        n_checks++;
        if (act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_idle_frame act=%h exp=%h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_level_shift();
        step(0, 1, 0, 0, 0);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.player_zone_y !== 11'd310) begin
            n_fail++; $display("FAIL level_enter_shift busy=%b y=%0d exp busy=1 y=310", bus.busy, bus.player_zone_y);
        end
        for (int f = 0; f < 16; f++) begin
            step(0, 0, 0, 0, 0);
            step(1, 0, 0, 0, 0);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL level_shift f=%0d act=%h exp=%h", f, act_vec(), exp_vec());
            end
        end
        n_checks++;
        if (bus.player_zone_y !== 11'd326 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL level_shift_end y=%0d busy=%b exp y=326 busy=0", bus.player_zone_y, bus.busy);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0);
        for (int f = 0; f < 100; f++) begin
            step(1, 0, 0, 0, 0);
            n_checks++;
            if (act_vec() !== exp_vec() || bus.player_zone_y > 11'd400) begin
                n_fail++; $display("FAIL saturation f=%0d act=%h exp=%h", f, act_vec(), exp_vec());
            end
        end
        n_checks++;
        if (bus.player_zone_y !== 11'd400 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL saturation_end y=%0d busy=%b exp y=400 busy=0", bus.player_zone_y, bus.busy);
        end
    endtask

    task automatic test_hit_idle();
        logic [7:0] want;
        step(1, 0, 1, 0, 0);
        for (int f = 0; f < FLASH_FRAMES; f++) begin
            want = ((f / 8) % 2 == 1) ? 8'hFF : 8'h80;
            n_checks++;
            if (bus.movement_zone_color !== want || act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL hit_idle_flash frame=%0d color=%h exp=%h act=%h expv=%h",
                                   f, bus.movement_zone_color, want, act_vec(), exp_vec());
            end
            step(1, 0, 0, 0, 0);
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.movement_zone_color !== 8'h80 || act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL hit_idle_end busy=%b color=%h exp busy=0 color=80", bus.busy, bus.movement_zone_color);
        end
    endtask

    task automatic test_gameover();
        step(0, 0, 1, 0, 0);
        for (int f = 0; f < 10; f++) step(1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        n_checks++;
        if (act_vec() !== {11'd400, 8'hE0, 8'hE0, 8'hE0, 1'b0}) begin
            n_fail++; $display("FAIL gameover_colors act=%h exp=%h", act_vec(), {11'd400, 8'hE0, 8'hE0, 8'hE0, 1'b0});
        end
        step(0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        for (int f = 0; f < 20; f++) begin
            step(1, (f == 3), (f == 7), 0, 0);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL frozen_ignore f=%0d act=%h exp=%h", f, act_vec(), exp_vec());
            end
        end
        step(0, 0, 0, 0, 1);
        n_checks++;
        if (act_vec() !== RST_VEC || act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL restart act=%h exp=%h", act_vec(), RST_VEC);
        end
    endtask

    task automatic test_hit_during_shift();
        int bound;
        step(0, 1, 0, 0, 0);
        for (int f = 0; f < 5; f++) step(1, 0, 0, 0, 0);
        n_checks++;
        if (bus.player_zone_y !== 11'd315) begin
            n_fail++; $display("FAIL shift_5_frames y=%0d exp=315", bus.player_zone_y);
        end
        step(1, 0, 1, 0, 0);
        for (int f = 0; f < FLASH_FRAMES; f++) begin
            step(1, 0, 0, 0, 0);
            n_checks++;
            if (act_vec() !== exp_vec() || (f < FLASH_FRAMES - 1 && bus.player_zone_y !== 11'd315)) begin
                n_fail++; $display("FAIL flash_hold f=%0d act=%h exp=%h", f, act_vec(), exp_vec());
            end
        end
        n_checks++;
        if (bus.busy !== 1'b1 || bus.player_zone_y !== 11'd315) begin
            n_fail++; $display("FAIL flash_to_shift busy=%b y=%0d exp busy=1 y=315", bus.busy, bus.player_zone_y);
        end
        bound = 0;
        while (bus.busy === 1'b1 && bound < 20) begin
            step(1, 0, 0, 0, 0);
            bound++;
        end
        n_checks++;
        if (bus.player_zone_y !== 11'd326 || bus.busy !== 1'b0 || bound != 11) begin
            n_fail++; $display("FAIL resume_shift y=%0d busy=%b frames=%0d exp y=326 busy=0 frames=11",
                               bus.player_zone_y, bus.busy, bound);
        end
    endtask

    task automatic test_hit_and_level();
        step(1, 1, 1, 0, 0);
        n_checks++;
        if (act_vec() !== exp_vec() || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL hit_and_level act=%h exp=%h", act_vec(), exp_vec());
        end
        for (int f = 0; f < 10; f++) step(1, 0, 0, 0, 0);
        n_checks++;
        if (bus.movement_zone_color !== 8'hFF || bus.player_zone_y !== 11'd326) begin
            n_fail++; $display("FAIL hit_and_level_flash color=%h y=%0d exp color=ff y=326",
                               bus.movement_zone_color, bus.player_zone_y);
        end
        #2 resetN = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (act_vec() !== RST_VEC) begin
            n_fail++; $display("FAIL async_reset act=%h exp=%h", act_vec(), RST_VEC);
        end
        @(posedge clk); #1 resetN = 1'b1;
        for (int f = 0; f < 5; f++) step(1, 0, 0, 0, 0);
        n_checks++;
        if (act_vec() !== RST_VEC) begin
            n_fail++; $display("FAIL no_pending_after_reset act=%h exp=%h", act_vec(), RST_VEC);
        end
        step(0, 1, 0, 0, 0);
        for (int f = 0; f < 20; f++) step(1, 0, 0, 0, 0);
        n_checks++;
        if (bus.player_zone_y !== 11'd326 || act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL target_after_reset y=%0d exp=326", bus.player_zone_y);
        end
    endtask

    task automatic test_random();
        bit sof, lu, ph, go, rs;
        for (int c = 0; c < 4000; c++) begin
            sof = ($urandom % 3) == 0;
            lu  = ($urandom % 40) == 0;
            ph  = ($urandom % 160) == 0;
            go  = ($urandom % 900) == 0;
            rs  = (m_mode == 3) ? (($urandom % 25) == 0) : (($urandom % 200) == 0);
            step(sof, lu, ph, go, rs);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random c=%0d act=%h exp=%h", c, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_level_shift();
        test_saturation();
        test_hit_idle();
        test_gameover();
        test_hit_during_shift();
        test_hit_and_level();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
